// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: latches device requests, masks and prioritises them,
// and presents one id to the CPU through an acknowledge / end-of-interrupt handshake.
module interrupt_controller #(
  parameter int              BITS     = 32,
  parameter int              NSRC     = 3,
  parameter logic [BITS-1:0] BASE     = 32'hF0000200,
  parameter logic [BITS-1:0] IDN_NONE = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  input  logic [NSRC-1:0] irq,
  output logic            inta,
  output logic [BITS-1:0] idn
);

  localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [BITS-1:0] A_PEND = BASE;
  localparam logic [BITS-1:0] A_MASK = BASE + BITS'(4);
  localparam logic [BITS-1:0] A_EOI  = BASE + BITS'(8);
  localparam logic [BITS-1:0] A_CUR  = BASE + BITS'(12);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_INSERVICE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cur_q, cur_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;

  logic            sel_pend, sel_mask, sel_eoi, sel_cur;
  logic            ack, eoi_fire, live;
  logic [NSRC-1:0] w1c, eoi_clr, candidate, cur_oh;
  logic [CW-1:0]   winner;
  logic [BITS-1:0] idn_cur;
  logic            unused_din;

  assign sel_pend = (memAddr == A_PEND);
  assign sel_mask = (memAddr == A_MASK);
  assign sel_eoi  = (memAddr == A_EOI);
  assign sel_cur  = (memAddr == A_CUR);

  assign ack       = re && sel_cur && (state_q == S_ASSERT);
  assign eoi_fire  = we && sel_eoi && (state_q == S_INSERVICE);
  assign cur_oh    = NSRC'(1) << cur_q;
  assign w1c       = (we && sel_pend) ? dataBusIn[NSRC-1:0] : '0;
  assign eoi_clr   = eoi_fire ? cur_oh : '0;
  assign mask_d    = (we && sel_mask) ? dataBusIn[NSRC-1:0] : mask_q;
  assign candidate = pend_q & mask_q;
  assign idn_cur   = BITS'(cur_q) + BITS'(1);
  assign unused_din = ^dataBusIn[BITS-1:NSRC];

  // A level request always wins over a clear arriving in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      assign pend_d[gi] = irq[gi] | (pend_q[gi] & ~w1c[gi] & ~eoi_clr[gi]);
    end
  endgenerate

  // Uses next-cycle pend/mask so a withdrawal drops inta one cycle after the write, like an ack.
  assign live = |(pend_d & mask_d & cur_oh);

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (candidate[i]) winner = CW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (|candidate) begin
          state_d = S_ASSERT;
          cur_d   = winner;
        end
      end
      S_ASSERT: begin
        if (ack)        state_d = S_INSERVICE;
        else if (!live) state_d = S_IDLE;
      end
      S_INSERVICE: begin
        if (eoi_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inta = (state_q == S_ASSERT);
    idn  = (state_q == S_IDLE) ? IDN_NONE : idn_cur;
  end

  // Shared OR bus: drive zero unless this block is being read.
  always_comb begin
    dataBusOut = '0;
    if (re) begin
      if (sel_pend)      dataBusOut = BITS'(pend_q);
      else if (sel_mask) dataBusOut = BITS'(mask_q);
      else if (sel_cur)  dataBusOut = idn;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios then random bus/irq traffic,
// every cycle compared against a behavioural model of the controller.
module tb_interrupt_controller;

  localparam logic [31:0] BASE   = 32'hF0000200;
  localparam logic [31:0] A_PEND = BASE;
  localparam logic [31:0] A_MASK = BASE + 32'd4;
  localparam logic [31:0] A_EOI  = BASE + 32'd8;
  localparam logic [31:0] A_CUR  = BASE + 32'd12;
  localparam logic [31:0] NONE   = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [31:0] memAddr, dataBusIn, dataBusOut, idn;
  logic [2:0]  irq;
  logic        inta;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = nothing presented, 1 = presented awaiting ack, 2 = being serviced.
  bit [2:0] m_pend, m_mask;
  int       m_phase, m_cur;
  bit       m_valid = 1'b0;

  logic        s_inta;
  logic [31:0] s_idn, s_dout;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusIn  (dataBusIn),
    .dataBusOut (dataBusOut),
    .irq        (irq),
    .inta       (inta),
    .idn        (idn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
    if (!r) return 32'h0;
    if (a == A_PEND) return {29'h0, m_pend};
    if (a == A_MASK) return {29'h0, m_mask};
    if (a == A_CUR)  return (m_phase == 0) ? NONE : 32'(m_cur + 1);
    return 32'h0;
  endfunction

  task automatic model_update(input logic rst, input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d, input logic [2:0] q);
    bit [2:0] clr, nmask, npend;
    bit       eoi;
    int       win;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_phase = 0; m_cur = 0; m_valid = 1'b1;
      return;
    end
    clr   = (w && a == A_PEND) ? d[2:0] : 3'b000;
    eoi   = w && (a == A_EOI) && (m_phase == 2);
    nmask = (w && a == A_MASK) ? d[2:0] : m_mask;
    for (int i = 0; i < 3; i++)
      npend[i] = q[i] || (m_pend[i] && !clr[i] && !(eoi && i == m_cur));
    if (m_phase == 0) begin
      win = -1;
      for (int i = 0; i < 3; i++)
        if (m_pend[i] && m_mask[i] && win < 0) win = i;
      if (win >= 0) begin m_cur = win; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (r && a == A_CUR) m_phase = 2;
      else if (!(npend[m_cur] && nmask[m_cur])) m_phase = 0;
    end else if (eoi) begin
      m_phase = 0;
    end
    m_pend = npend;
    m_mask = nmask;
  endtask

  task automatic tick(input logic rst, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] q);
    reset = rst; we = w; re = r; memAddr = a; dataBusIn = d; irq = q;
    @(negedge clk);
    s_inta = inta; s_idn = idn; s_dout = dataBusOut;
    $display("t=%0t rst=%0b we=%0b re=%0b addr=%h din=%h irq=%b -> inta=%0b idn=%h dout=%h",
             $time, rst, w, r, a, d, q, s_inta, s_idn, s_dout);
    if (m_valid) begin
      chk("model_inta", {31'h0, s_inta}, {31'h0, m_phase == 1});
      chk("model_idn", s_idn, (m_phase == 0) ? NONE : 32'(m_cur + 1));
      chk("model_dout", s_dout, model_read(r, a));
    end
    @(posedge clk);
    model_update(rst, w, r, a, d, q);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0; irq = '0;
    @(posedge clk); #1;
    tick(1, 0, 0, 0, 0, 3'b000);
    tick(1, 0, 0, 0, 0, 3'b000);

    // 1: request with everything masked
    tick(0, 0, 0, 0, 0, 3'b001);
    tick(0, 0, 1, A_PEND, 0, 3'b001);
    chk("t1_pend", s_dout, 32'h1);
    chk("t1_inta", {31'h0, s_inta}, 32'h0);
    chk("t1_idn", s_idn, NONE);
    tick(0, 1, 0, A_PEND, 32'h7, 3'b000);

    // 2: mask on, key+switch pending, ack and EOI
    tick(0, 1, 0, A_MASK, 32'h7, 3'b110);
    tick(0, 0, 0, 0, 0, 3'b000);
    tick(0, 0, 1, A_CUR, 0, 3'b000);
    chk("t2_inta", {31'h0, s_inta}, 32'h1);
    chk("t2_cur", s_dout, 32'h2);
    tick(0, 1, 0, A_EOI, 32'h0, 3'b000);
    chk("t2_inta_drop", {31'h0, s_inta}, 32'h0);
    chk("t2_idn_svc", s_idn, 32'h2);
    tick(0, 0, 1, A_PEND, 0, 3'b000);
    chk("t2_pend", s_dout, 32'h4);

    // 3: higher priority arrival does not preempt
    tick(0, 0, 0, 0, 0, 3'b001);
    chk("t3_idn3", s_idn, 32'h3);
    tick(0, 0, 0, 0, 0, 3'b000);
    chk("t3_frozen", s_idn, 32'h3);
    tick(0, 0, 1, A_CUR, 0, 3'b000);
    chk("t3_ack", s_dout, 32'h3);
    tick(0, 1, 0, A_EOI, 32'h5, 3'b000);
    tick(0, 0, 0, 0, 0, 3'b000);
    tick(0, 0, 0, 0, 0, 3'b000);
    chk("t3_next_idn", s_idn, 32'h1);
    chk("t3_next_inta", {31'h0, s_inta}, 32'h1);

    // 4: withdrawal by masking
    tick(0, 0, 1, A_CUR, 0, 3'b000);
    tick(0, 1, 0, A_EOI, 0, 3'b010);
    tick(0, 0, 0, 0, 0, 3'b000);
    tick(0, 1, 0, A_MASK, 32'h0, 3'b000);
    chk("t4_idn2", s_idn, 32'h2);
    tick(0, 0, 1, A_PEND, 0, 3'b000);
    chk("t4_inta", {31'h0, s_inta}, 32'h0);
    chk("t4_pend", s_dout, 32'h2);

    // 5: collisions
    tick(0, 1, 0, A_PEND, 32'h1, 3'b001);
    tick(0, 1, 0, A_EOI, 32'h0, 3'b000);
    tick(0, 0, 1, A_PEND, 0, 3'b000);
    chk("t5_pend", s_dout, 32'h3);
    chk("t5_idn", s_idn, NONE);

    // 6: reset while in service
    tick(0, 1, 0, A_MASK, 32'h7, 3'b000);
    tick(0, 0, 0, 0, 0, 3'b000);
    tick(0, 0, 1, A_CUR, 0, 3'b000);
    chk("t6_ack", s_dout, 32'h1);
    tick(0, 0, 0, 0, 0, 3'b000);
    tick(1, 0, 0, 0, 0, 3'b000);
    tick(0, 0, 1, A_CUR, 0, 3'b000);
    chk("t6_cur", s_dout, NONE);
    chk("t6_inta", {31'h0, s_inta}, 32'h0);
    tick(0, 0, 1, A_MASK, 0, 3'b000);
    chk("t6_mask", s_dout, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, d;
      logic [2:0]  q;
      int          sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = A_PEND;
        1: a = A_MASK;
        2: a = A_EOI;
        3, 4: a = A_CUR;
        default: a = ($urandom_range(0, 1) == 0) ? BASE + 32'h10 : $urandom;
      endcase
      d = $urandom;
      for (int i = 0; i < 3; i++) q[i] = ($urandom_range(0, 5) == 0);
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0), a, d, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
